// File: rtl/sha256_pkg.sv
// sha256_pkg: shared definitions for the SHA-256 round core and its
// neighbours.
//   state_t      FSM encoding (IDLE, LOAD_H, INIT, ROUND, OUT, DONE)
//   HSEL/KSEL    HK_SELECTOR values of the H/K constant memory
//   work_t       eight 32-bit words, index 0 = a (or H0) ... 7 = h (or H7)
//   big_sigma0/1, ch, maj  SHA-256 round functions
package sha256_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_H = 3'd1,
    ST_INIT   = 3'd2,
    ST_ROUND  = 3'd3,
    ST_OUT    = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam logic HSEL = 1'b0;
  localparam logic KSEL = 1'b1;

  typedef logic [7:0][31:0] work_t;

  // Rotations are written as fixed concatenations: ROTR^n(x) = {x[n-1:0], x[31:n]}.
  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_round_core_if.sv
// sha256_round_core_if: memory-side bus of the round core.
//   MEM_RDY      constant memory ready (START is ignored while low)
//   HK_SELECTOR  0 = H constants, 1 = K constants
//   H_ADDR       H constant address (3 bits)
//   K_ADDR       K constant address (6 bits)
//   HK           constant data, valid one cycle after its address
//   W_ADDR       message schedule address (6 bits)
//   W            schedule data, valid one cycle after W_ADDR
// Handshake: there is no valid/ready pair on this bus. Addresses are
// accepted every cycle and the memories must return data exactly one cycle
// later; the core never stalls. MEM_RDY only gates the acceptance of START.
// master = round core, slave = H/K memory plus W memory.
interface sha256_round_core_if;
  logic        MEM_RDY;
  logic        HK_SELECTOR;
  logic [2:0]  H_ADDR;
  logic [5:0]  K_ADDR;
  logic [31:0] HK;
  logic [5:0]  W_ADDR;
  logic [31:0] W;

  modport master (
    input  MEM_RDY,
    input  HK,
    input  W,
    output HK_SELECTOR,
    output H_ADDR,
    output K_ADDR,
    output W_ADDR
  );

  modport slave (
    output MEM_RDY,
    output HK,
    output W,
    input  HK_SELECTOR,
    input  H_ADDR,
    input  K_ADDR,
    input  W_ADDR
  );
endinterface

// File: rtl/sha256_round.sv
// sha256_round: one SHA-256 compression round, purely combinational.
//   cur  working registers a..h (index 0 = a)
//   k    round constant K[t]
//   w    schedule word W[t]
//   nxt  working registers after the round
module sha256_round
  import sha256_pkg::*;
(
  input  work_t       cur,
  input  logic [31:0] k,
  input  logic [31:0] w,
  output work_t       nxt
);

  logic [31:0] t1;
  logic [31:0] t2;

  always_comb begin
    t1 = cur[7] + big_sigma1(cur[4]) + ch(cur[4], cur[5], cur[6]) + k + w;
    t2 = big_sigma0(cur[0]) + maj(cur[0], cur[1], cur[2]);
    nxt    = cur;
    nxt[0] = t1 + t2;       // a
    nxt[1] = cur[0];        // b <- a
    nxt[2] = cur[1];        // c <- b
    nxt[3] = cur[2];        // d <- c
    nxt[4] = cur[3] + t1;   // e <- d + T1
    nxt[5] = cur[4];        // f <- e
    nxt[6] = cur[5];        // g <- f
    nxt[7] = cur[6];        // h <- g
  end

endmodule

// File: rtl/sha256_round_core.sv
// sha256_round_core: SHA-256 compression of one 512-bit block.
// Reads H/K constants from the constant memory and W[t] from an external
// schedule memory, runs 64 rounds, then emits the eight updated hash words
// one per cycle and pulses DONE. CHAIN=1 reuses the internal hash state so
// multi-block messages can be processed back to back.
//   CLK, RST_N      clock, synchronous active-low reset
//   mem             memory bus (master side), see sha256_round_core_if
//   START, CHAIN    block request, sampled only in IDLE with MEM_RDY=1
//   BUSY            high in every state except IDLE
//   DIGEST_VALID/DIGEST_IDX/DIGEST  updated hash word i during OUT
//   DONE            one-cycle completion pulse
//   DBG_STATE       current FSM state
module sha256_round_core
  import sha256_pkg::*;
#(
  parameter int ROUNDS = 64
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  sha256_round_core_if.master        mem,
  input  logic                       START,
  input  logic                       CHAIN,
  output logic                       BUSY,
  output logic                       DIGEST_VALID,
  output logic [2:0]                 DIGEST_IDX,
  output logic [31:0]                DIGEST,
  output logic                       DONE,
  output state_t                     DBG_STATE
);

  localparam int CW = $clog2(ROUNDS + 1);
  localparam logic [CW-1:0] LOAD_LAST = CW'(8);
  localparam logic [CW-1:0] ROUND_LAST = CW'(ROUNDS);
  // Address counters stop advancing once they reach the last round index.
  localparam logic [CW-1:0] ADDR_LAST = CW'(ROUNDS - 1);

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [31:0]     h_q [8];
  work_t           work_q;
  work_t           work_nxt;

  logic            hk_sel_q;
  logic [2:0]      h_addr_q;
  logic [5:0]      k_addr_q;
  logic [5:0]      w_addr_q;
  logic            busy_q;
  logic            done_q;
  logic            dv_q;
  logic [2:0]      didx_q;

  logic [2:0]      load_idx;
  logic [31:0]     digest_word;

  // In LOAD_H cycle c the data on HK belongs to address c-1.
  assign load_idx    = 3'(cnt_q - 1'b1);
  assign digest_word = h_q[didx_q] + work_q[didx_q];

  sha256_round u_round (
    .cur (work_q),
    .k   (mem.HK),
    .w   (mem.W),
    .nxt (work_nxt)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      work_q   <= '0;
      hk_sel_q <= 1'b0;
      h_addr_q <= '0;
      k_addr_q <= '0;
      w_addr_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dv_q     <= 1'b0;
      didx_q   <= '0;
      for (int i = 0; i < 8; i++) h_q[i] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (START && mem.MEM_RDY) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            if (CHAIN) begin
              state_q <= ST_INIT;
            end else begin
              state_q  <= ST_LOAD_H;
              hk_sel_q <= HSEL;
              h_addr_q <= '0;
            end
          end
        end

        ST_LOAD_H: begin
          // The constant lands in both the hash state and the working
          // register, which lets a fresh block skip INIT.
          if (cnt_q != '0) begin
            h_q[load_idx]    <= mem.HK;
            work_q[load_idx] <= mem.HK;
          end
          if (cnt_q == LOAD_LAST) begin
            state_q  <= ST_ROUND;
            cnt_q    <= '0;
            hk_sel_q <= KSEL;
            k_addr_q <= '0;
            w_addr_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (h_addr_q != 3'd7) h_addr_q <= h_addr_q + 3'd1;
          end
        end

        ST_INIT: begin
          for (int i = 0; i < 8; i++) work_q[i] <= h_q[i];
          state_q  <= ST_ROUND;
          cnt_q    <= '0;
          hk_sel_q <= KSEL;
          k_addr_q <= '0;
          w_addr_q <= '0;
        end

        ST_ROUND: begin
          // Round t-1 executes in cycle t, when K/W for address t-1 arrive.
          if (cnt_q != '0) work_q <= work_nxt;
          if (cnt_q == ROUND_LAST) begin
            state_q <= ST_OUT;
            cnt_q   <= '0;
            dv_q    <= 1'b1;
            didx_q  <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q < ADDR_LAST) begin
              k_addr_q <= k_addr_q + 6'd1;
              w_addr_q <= w_addr_q + 6'd1;
            end
          end
        end

        ST_OUT: begin
          h_q[didx_q] <= digest_word;
          if (didx_q == 3'd7) begin
            state_q <= ST_DONE;
            dv_q    <= 1'b0;
            didx_q  <= '0;
            done_q  <= 1'b1;
          end else begin
            didx_q <= didx_q + 3'd1;
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          dv_q    <= 1'b0;
        end
      endcase
    end
  end

  assign mem.HK_SELECTOR = hk_sel_q;
  assign mem.H_ADDR      = h_addr_q;
  assign mem.K_ADDR      = k_addr_q;
  assign mem.W_ADDR      = w_addr_q;

  assign BUSY         = busy_q;
  assign DONE         = done_q;
  assign DIGEST_VALID = dv_q;
  assign DIGEST_IDX   = didx_q;
  assign DIGEST       = dv_q ? digest_word : 32'd0;
  assign DBG_STATE    = state_q;

endmodule
